// File: rtl/window_3x3_gen_if.sv
// Pixel-in / window-out handshake bundle for window_3x3_gen.
// win_count_o exists only when WIN3X3_COUNT_EN is defined.
interface window_3x3_gen_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] pix_i;
  logic              pix_valid_i;
  logic              pix_ready_o;
  logic [DATA_W-1:0] data_o_0;
  logic [DATA_W-1:0] data_o_1;
  logic [DATA_W-1:0] data_o_2;
  logic [DATA_W-1:0] data_o_3;
  logic [DATA_W-1:0] data_o_4;
  logic [DATA_W-1:0] data_o_5;
  logic [DATA_W-1:0] data_o_6;
  logic [DATA_W-1:0] data_o_7;
  logic [DATA_W-1:0] data_o_8;
  logic              win_valid_o;
  logic              win_ready_i;
  logic              frame_done_o;
`ifdef WIN3X3_COUNT_EN
  logic [16:0]       win_count_o;
`endif

  modport slave (
    input  pix_i, pix_valid_i, win_ready_i,
    output pix_ready_o, data_o_0, data_o_1, data_o_2, data_o_3, data_o_4,
           data_o_5, data_o_6, data_o_7, data_o_8, win_valid_o, frame_done_o
`ifdef WIN3X3_COUNT_EN
    , output win_count_o
`endif
  );

  modport master (
    output pix_i, pix_valid_i, win_ready_i,
    input  pix_ready_o, data_o_0, data_o_1, data_o_2, data_o_3, data_o_4,
           data_o_5, data_o_6, data_o_7, data_o_8, win_valid_o, frame_done_o
`ifdef WIN3X3_COUNT_EN
    , input win_count_o
`endif
  );
endinterface

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift array.
// Define WIN3X3_COUNT_EN to add the per-frame accepted-window counter win_count_o.
module window_3x3_gen #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int DATA_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  window_3x3_gen_if.slave  bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {FILL, RUN, HOLD} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];
  logic [DATA_W-1:0] lb1_rd, lb2_rd;
  logic [DATA_W-1:0] win_p1 [3][3];
  logic              last_p1;
  logic              frame_done;
  logic              pix_acc, win_acc, win_load;
  logic              col_last, row_last;

  assign bus.win_valid_o = (state == HOLD);
  assign bus.pix_ready_o = en_i & (~bus.win_valid_o | bus.win_ready_i);
  assign pix_acc  = bus.pix_valid_i & bus.pix_ready_o;
  assign win_acc  = en_i & bus.win_valid_o & bus.win_ready_i;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  // Outside FILL every accepted pixel is on row >= 2, so only the column gates a window.
  assign win_load = pix_acc & (col >= CW'(2)) & (state != FILL);

  assign lb1_rd = lb1[col];
  assign lb2_rd = lb2[col];

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (pix_acc && row == RW'(2) && col == '0) state_nxt = RUN;
      RUN:  if (win_load) state_nxt = HOLD;
      HOLD: begin
        if (win_acc) begin
          if (last_p1)       state_nxt = FILL;
          else if (win_load) state_nxt = HOLD;
          else               state_nxt = RUN;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Stage p1: counters, FSM and window array update on each accepted pixel
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= FILL;
      col        <= '0;
      row        <= '0;
      last_p1    <= 1'b0;
      frame_done <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_p1[r][c] <= '0;
    end else if (en_i) begin
      state      <= state_nxt;
      frame_done <= win_acc & last_p1;
      if (win_load) last_p1 <= row_last & col_last;
      if (pix_acc) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        for (int r = 0; r < 3; r++) begin
          win_p1[r][0] <= win_p1[r][1];
          win_p1[r][1] <= win_p1[r][2];
        end
        win_p1[0][2] <= lb2_rd;
        win_p1[1][2] <= lb1_rd;
        win_p1[2][2] <= bus.pix_i;
      end
    end
  end

  // Line buffers are storage only; their contents are always written before being read.
  always_ff @(posedge clk_i) begin
    if (pix_acc) begin
      lb2[col] <= lb1_rd;
      lb1[col] <= bus.pix_i;
    end
  end

`ifdef WIN3X3_COUNT_EN
  logic [16:0] win_count;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       win_count <= '0;
    else if (win_acc) win_count <= last_p1 ? '0 : win_count + 17'd1;
  end

  assign bus.win_count_o = win_count;
`endif

  assign bus.data_o_0     = win_p1[0][0];
  assign bus.data_o_1     = win_p1[0][1];
  assign bus.data_o_2     = win_p1[0][2];
  assign bus.data_o_3     = win_p1[1][0];
  assign bus.data_o_4     = win_p1[1][1];
  assign bus.data_o_5     = win_p1[1][2];
  assign bus.data_o_6     = win_p1[2][0];
  assign bus.data_o_7     = win_p1[2][1];
  assign bus.data_o_8     = win_p1[2][2];
  assign bus.frame_done_o = frame_done;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen on a reduced 10x6 frame: frame-array reference model plus directed streams.
module tb_window_3x3_gen;
  localparam int W    = 10;
  localparam int H    = 6;
  localparam int DW   = 8;
  localparam int NWIN = (W - 2) * (H - 2);

  logic clk   = 1'b0;
  logic rst_i = 1'b0;
  logic en_i  = 1'b1;

  always #5 clk = ~clk;

  window_3x3_gen_if #(.DATA_W(DW)) bus ();

  window_3x3_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .en_i  (en_i),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [7:0] pixval(input int sel, input int r, input int c);
    int i;
    i = r * W + c;
    case (sel)
      0:       return 8'(i);
      1:       return 8'(i * 7 + 3);
      default: return 8'(255 - i * 3);
    endcase
  endfunction

  function automatic logic [71:0] dvec();
    return {bus.data_o_8, bus.data_o_7, bus.data_o_6, bus.data_o_5, bus.data_o_4,
            bus.data_o_3, bus.data_o_2, bus.data_o_1, bus.data_o_0};
  endfunction

  // Reference model: frame image plus queue of pending windows
  typedef struct packed {
    logic [71:0] d;
    logic        last;
  } wexp_t;

  wexp_t      q[$];
  logic [7:0] img [H][W];
  int  mr = 0, mc = 0;
  bit  exp_done = 1'b0;
  int  frame_wins = 0, all_wins = 0, pulses = 0, mcount = 0;

  always @(negedge clk) begin : compare
    bit    wv, wr, pv, pr, en, nd;
    wexp_t e;
    if (!rst_i) begin
      q.delete();
      mr = 0; mc = 0; exp_done = 1'b0; frame_wins = 0; mcount = 0;
    end else begin
      wv = bus.win_valid_o; wr = bus.win_ready_i;
      pv = bus.pix_valid_i; pr = bus.pix_ready_o; en = en_i;
      check("pix_ready", 72'(pr), 72'(en & (~wv | wr)));
      check("win_valid", 72'(wv), 72'(q.size() != 0));
      check("frame_done", 72'(bus.frame_done_o), 72'(exp_done));
      if (bus.frame_done_o) pulses++;
`ifdef WIN3X3_COUNT_EN
      check("win_count", 72'(bus.win_count_o), 72'(mcount));
`endif
      if (wv && q.size() != 0) check("window", dvec(), q[0].d);
      nd = exp_done;
      if (en) nd = 1'b0;
      if (en && wv && wr && q.size() != 0) begin
        e = q.pop_front();
        frame_wins++; all_wins++; mcount++;
        if (e.last) begin
          check("frame_windows", 72'(frame_wins), 72'(NWIN));
`ifdef WIN3X3_COUNT_EN
          check("win_count_last", 72'(bus.win_count_o), 72'(NWIN - 1));
`endif
          frame_wins = 0; mcount = 0; nd = 1'b1;
        end
      end
      if (en && pv && pr) begin
        img[mr][mc] = bus.pix_i;
        if (mr >= 2 && mc >= 2) begin
          for (int k = 0; k < 9; k++)
            e.d[k*8 +: 8] = img[mr - 2 + k / 3][mc - 2 + k % 3];
          e.last = (mr == H - 1) && (mc == W - 1);
          q.push_back(e);
        end
        if (mc == W - 1) begin
          mc = 0;
          mr = (mr == H - 1) ? 0 : mr + 1;
        end else begin
          mc = mc + 1;
        end
      end
      exp_done = nd;
    end
  end

  int drv_r = 0, drv_c = 0;

  // Sends npix pixels; optional 5-cycle window backpressure and 10-cycle en_i drop.
  task automatic stream(input int npix, input int sel, input int bp_at, input int en_at);
    int sent = 0, guard = 0, bp_left = 0, en_left = 0, ar, ac;
    bit bp_done = 1'b0, en_done = 1'b0, acc;
    logic [7:0] held = '0;
    while (sent < npix && guard < npix * 3 + 40) begin
      if (!bp_done && sent == bp_at && bus.win_valid_o) begin
        bp_done = 1'b1; bp_left = 5; held = bus.data_o_4;
      end
      if (!en_done && sent == en_at) begin
        en_done = 1'b1; en_left = 10;
      end
      bus.win_ready_i = (bp_left == 0);
      en_i            = (en_left == 0);
      bus.pix_valid_i = 1'b1;
      bus.pix_i       = pixval(sel, drv_r, drv_c);
      @(negedge clk);
      acc = en_i & bus.pix_valid_i & bus.pix_ready_o;
      if (bp_left > 0) begin
        check("bp_ready", 72'(bus.pix_ready_o), 72'(0));
        check("bp_hold", 72'(bus.data_o_4), 72'(held));
      end
      if (en_left > 0) begin
        check("en_ready", 72'(bus.pix_ready_o), 72'(0));
        check("en_valid_hold", 72'(bus.win_valid_o), 72'(1));
      end
      @(posedge clk); #1;
      guard++;
      if (bp_left > 0) bp_left--;
      if (en_left > 0) en_left--;
      if (acc) begin
        ar = drv_r; ac = drv_c;
        sent++;
        if (drv_c == W - 1) begin
          drv_c = 0;
          drv_r = (drv_r == H - 1) ? 0 : drv_r + 1;
        end else begin
          drv_c = drv_c + 1;
        end
        if (sel == 0 && ar == 2 && ac == 2) begin
          check("first_win_valid", 72'(bus.win_valid_o), 72'(1));
          check("first_win_d0", 72'(bus.data_o_0), 72'(0));
          check("first_win_d4", 72'(bus.data_o_4), 72'(11));
          check("first_win_d8", 72'(bus.data_o_8), 72'(22));
        end
        if (sel == 0 && ar == 3 && ac < 2)
          check("line_start_no_win", 72'(bus.win_valid_o), 72'(0));
        if (sel == 0 && ar == 3 && ac == 2) begin
          check("row3_win_valid", 72'(bus.win_valid_o), 72'(1));
          check("row3_d0", 72'(bus.data_o_0), 72'(10));
          check("row3_d8", 72'(bus.data_o_8), 72'(32));
        end
      end
    end
    if (sent < npix) check("stream_timeout", 72'(sent), 72'(npix));
    bus.pix_valid_i = 1'b0;
    bus.win_ready_i = 1'b1;
    en_i            = 1'b1;
  endtask

  initial begin
    bus.pix_i       = '0;
    bus.pix_valid_i = 1'b0;
    bus.win_ready_i = 1'b1;
    en_i            = 1'b1;
    rst_i           = 1'b0;
    #3;
    check("rst_win_valid", 72'(bus.win_valid_o), 72'(0));
    check("rst_frame_done", 72'(bus.frame_done_o), 72'(0));
    check("rst_data", dvec(), 72'(0));
    check("rst_ready_en1", 72'(bus.pix_ready_o), 72'(1));
`ifdef WIN3X3_COUNT_EN
    check("rst_count", 72'(bus.win_count_o), 72'(0));
`endif
    en_i = 1'b0;
    #1;
    check("rst_ready_en0", 72'(bus.pix_ready_o), 72'(0));
    en_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b1;
    drv_r = 0; drv_c = 0;

    stream(H * W, 0, 35, 45);
    stream(H * W, 1, -1, -1);
    stream(35, 1, -1, -1);

    rst_i = 1'b0;
    #1;
    check("midrst_win_valid", 72'(bus.win_valid_o), 72'(0));
    check("midrst_data", dvec(), 72'(0));
    check("midrst_ready", 72'(bus.pix_ready_o), 72'(1));
    @(posedge clk); #1;
    rst_i = 1'b1;
    drv_r = 0; drv_c = 0;

    stream(H * W, 2, -1, -1);
    repeat (4) @(posedge clk);
    #1;
    check("frame_done_pulses", 72'(pulses), 72'(3));
    check("windows_accepted", 72'(all_wins), 72'(106));
    check("drained", 72'(bus.win_valid_o), 72'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
